// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream signals around the memory-port arbiter.
// The slave modport is the arbiter's view; master is the core/downstream environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_ready;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ready;
    logic [ADDR_WIDTH-1:0] dn_addr;
    logic [DATA_WIDTH-1:0] dn_wdata;
    logic                  dn_we;
    logic                  dn_re;
    logic [DATA_WIDTH-1:0] dn_rdata;
    logic                  dn_ready;
    logic                  busy;
    logic                  owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, dn_rdata, dn_ready,
        output i_rdata, i_ready, d_rdata, d_ready, dn_addr, dn_wdata, dn_we, dn_re, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, dn_rdata, dn_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, dn_addr, dn_wdata, dn_we, dn_re, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and load/store.
// Data has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                state_r, state_nxt_s;
    logic [CW-1:0]         starve_cnt_r, starve_cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] dn_addr_r, dn_addr_nxt_s;
    logic [DATA_WIDTH-1:0] dn_wdata_r, dn_wdata_nxt_s;
    logic [DATA_WIDTH-1:0] i_rdata_r, i_rdata_nxt_s;
    logic [DATA_WIDTH-1:0] d_rdata_r, d_rdata_nxt_s;
    logic                  dn_we_r, dn_we_nxt_s;
    logic                  dn_re_r, dn_re_nxt_s;
    logic                  i_ready_r, i_ready_nxt_s;
    logic                  d_ready_r, d_ready_nxt_s;
    logic                  owner_r, owner_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic                  grant_d_s;

    // Data wins unless fetch is waiting and has already lost STARVE_LIMIT times in a row.
    assign grant_d_s = bus.d_req && !(bus.i_req && (starve_cnt_r == LIMIT_C));

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s      = state_r;
        starve_cnt_nxt_s = starve_cnt_r;
        dn_addr_nxt_s    = dn_addr_r;
        dn_wdata_nxt_s   = dn_wdata_r;
        i_rdata_nxt_s    = i_rdata_r;
        d_rdata_nxt_s    = d_rdata_r;
        dn_we_nxt_s      = 1'b0;
        dn_re_nxt_s      = 1'b0;
        i_ready_nxt_s    = 1'b0;
        d_ready_nxt_s    = 1'b0;
        owner_nxt_s      = owner_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s    = WAIT;
                    owner_nxt_s    = 1'b1;
                    dn_addr_nxt_s  = bus.d_addr;
                    dn_wdata_nxt_s = bus.d_wdata;
                    dn_we_nxt_s    = bus.d_we;
                    dn_re_nxt_s    = !bus.d_we;
                    if (!bus.i_req) begin
                        starve_cnt_nxt_s = '0;
                    end else if (starve_cnt_r != LIMIT_C) begin
                        starve_cnt_nxt_s = starve_cnt_r + CW'(1);
                    end else begin
                        starve_cnt_nxt_s = starve_cnt_r;
                    end
                end else if (bus.i_req) begin
                    state_nxt_s      = WAIT;
                    owner_nxt_s      = 1'b0;
                    dn_addr_nxt_s    = bus.i_addr;
                    dn_re_nxt_s      = 1'b1;
                    starve_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // Requester inputs are not looked at here; the granted request is already latched.
                if (bus.dn_ready) begin
                    state_nxt_s = IDLE;
                    if (owner_r) begin
                        d_rdata_nxt_s = bus.dn_rdata;
                        d_ready_nxt_s = 1'b1;
                    end else begin
                        i_rdata_nxt_s = bus.dn_rdata;
                        i_ready_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == WAIT);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            starve_cnt_r <= '0;
            dn_addr_r    <= '0;
            dn_wdata_r   <= '0;
            i_rdata_r    <= '0;
            d_rdata_r    <= '0;
            dn_we_r      <= 1'b0;
            dn_re_r      <= 1'b0;
            i_ready_r    <= 1'b0;
            d_ready_r    <= 1'b0;
            owner_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            dn_addr_r    <= dn_addr_nxt_s;
            dn_wdata_r   <= dn_wdata_nxt_s;
            i_rdata_r    <= i_rdata_nxt_s;
            d_rdata_r    <= d_rdata_nxt_s;
            dn_we_r      <= dn_we_nxt_s;
            dn_re_r      <= dn_re_nxt_s;
            i_ready_r    <= i_ready_nxt_s;
            d_ready_r    <= d_ready_nxt_s;
            owner_r      <= owner_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign bus.dn_addr  = dn_addr_r;
    assign bus.dn_wdata = dn_wdata_r;
    assign bus.dn_we    = dn_we_r;
    assign bus.dn_re    = dn_re_r;
    assign bus.i_rdata  = i_rdata_r;
    assign bus.i_ready  = i_ready_r;
    assign bus.d_rdata  = d_rdata_r;
    assign bus.d_ready  = d_ready_r;
    assign bus.owner    = owner_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction at a time, tracked as plain records.
    bit          m_busy, m_owner, m_we, m_re, m_ir, m_dr;
    int          m_streak;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0; m_owner <= 1'b0; m_we <= 1'b0; m_re <= 1'b0;
            m_ir <= 1'b0; m_dr <= 1'b0; m_streak <= 0;
            m_addr <= 32'h0; m_wdata <= 32'h0; m_ird <= 32'h0; m_drd <= 32'h0;
        end else begin
            m_we <= 1'b0; m_re <= 1'b0; m_ir <= 1'b0; m_dr <= 1'b0;
            if (m_busy) begin
                if (bus.dn_ready) begin
                    m_busy <= 1'b0;
                    if (m_owner) begin m_drd <= bus.dn_rdata; m_dr <= 1'b1; end
                    else begin m_ird <= bus.dn_rdata; m_ir <= 1'b1; end
                end
            end else if (bus.d_req && !(bus.i_req && m_streak >= LIMIT)) begin
                m_busy <= 1'b1; m_owner <= 1'b1;
                m_addr <= bus.d_addr; m_wdata <= bus.d_wdata;
                if (bus.d_we) m_we <= 1'b1; else m_re <= 1'b1;
                m_streak <= bus.i_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
            end else if (bus.i_req) begin
                m_busy <= 1'b1; m_owner <= 1'b0; m_addr <= bus.i_addr;
                m_re <= 1'b1; m_streak <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("dn_addr",  bus.dn_addr,  m_addr);
        chk("dn_wdata", bus.dn_wdata, m_wdata);
        chk("dn_we",    {31'h0, bus.dn_we},   {31'h0, m_we});
        chk("dn_re",    {31'h0, bus.dn_re},   {31'h0, m_re});
        chk("i_ready",  {31'h0, bus.i_ready}, {31'h0, m_ir});
        chk("d_ready",  {31'h0, bus.d_ready}, {31'h0, m_dr});
        chk("i_rdata",  bus.i_rdata,  m_ird);
        chk("d_rdata",  bus.d_rdata,  m_drd);
        chk("busy",     {31'h0, bus.busy},    {31'h0, m_busy});
        chk("owner",    {31'h0, bus.owner},   {31'h0, m_owner});
    end

    // Activity monitor: strobe/ready counts and the order of grants.
    int re_cnt = 0, we_cnt = 0, ir_cnt = 0, dr_cnt = 0;
    bit grants[$];
    always @(negedge clk) begin
        if (bus.dn_re || bus.dn_we) grants.push_back(bus.owner);
        if (bus.dn_re)   re_cnt++;
        if (bus.dn_we)   we_cnt++;
        if (bus.i_ready) ir_cnt++;
        if (bus.d_ready) dr_cnt++;
    end

    // Downstream responder: answers a strobe after resp_lat cycles, or emits a requested stray pulse.
    bit          resp_en  = 1'b1;
    int          resp_lat = 2;
    logic [31:0] resp_data = 32'h0;
    int          spur_cnt = 0, spur_done = 0;
    logic [31:0] spur_data = 32'h0;
    initial begin
        bus.dn_ready = 1'b0;
        bus.dn_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (spur_cnt != spur_done) begin
                spur_done++;
                #1 bus.dn_rdata = spur_data; bus.dn_ready = 1'b1;
                @(posedge clk);
                #1 bus.dn_ready = 1'b0;
            end else if (resp_en && resetn && (bus.dn_we || bus.dn_re)) begin
                repeat (resp_lat) @(posedge clk);
                #1 bus.dn_rdata = resp_data; bus.dn_ready = 1'b1;
                @(posedge clk);
                #1 bus.dn_ready = 1'b0;
            end
        end
    end

    // Waits for 0=i_ready, 1=d_ready, 2=any strobe; an expired bound counts as a failure.
    task automatic wait_for(input int which, input int max, input string name);
        for (int k = 0; k < max; k++) begin
            @(posedge clk); #1;
            if ((which == 0 && bus.i_ready) || (which == 1 && bus.d_ready) ||
                (which == 2 && (bus.dn_re || bus.dn_we))) return;
        end
        tests++; fails++;
        $display("FAIL %s: timeout after %0d cycles", name, max);
    endtask

    int          re0, we0, ir0, dr0;
    string       exp_seq;
    initial begin
        resetn = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_dn_addr", bus.dn_addr, 32'h0);
        chk("rst_owner", {31'h0, bus.owner}, 32'h0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: fetch only
        #1;
        re0 = re_cnt; we0 = we_cnt; dr0 = dr_cnt; ir0 = ir_cnt;
        resp_lat = 2; resp_data = 32'h0000_0013;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
        wait_for(0, 30, "t1_i_ready");
        bus.i_req = 1'b0;
        chk("t1_i_rdata", bus.i_rdata, 32'h0000_0013);
        chk("t1_dn_addr", bus.dn_addr, 32'h0000_0100);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_re_pulses", re_cnt - re0, 32'd1);
        chk("t1_we_pulses", we_cnt - we0, 32'd0);
        chk("t1_i_ready_pulses", ir_cnt - ir0, 32'd1);
        chk("t1_d_ready_pulses", dr_cnt - dr0, 32'd0);

        // 2: data write
        re0 = re_cnt; we0 = we_cnt; dr0 = dr_cnt;
        resp_data = 32'h5555_AAAA;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_2000; bus.d_wdata = 32'hDEAD_BEEF;
        wait_for(1, 30, "t2_d_ready");
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_we_pulses", we_cnt - we0, 32'd1);
        chk("t2_re_pulses", re_cnt - re0, 32'd0);
        chk("t2_dn_wdata", bus.dn_wdata, 32'hDEAD_BEEF);
        chk("t2_dn_addr", bus.dn_addr, 32'h0000_2000);
        chk("t2_d_ready_pulses", dr_cnt - dr0, 32'd1);

        // 3: simultaneous requests, data first then fetch
        grants.delete();
        resp_data = 32'h1234_5678;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_3000;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0104;
        wait_for(1, 30, "t3_d_ready");
        bus.d_req = 1'b0;
        wait_for(0, 30, "t3_i_ready");
        bus.i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_grant_count", grants.size(), 32'd2);
        if (grants.size() == 2) begin
            chk("t3_first_grant", {31'h0, grants[0]}, 32'd1);
            chk("t3_second_grant", {31'h0, grants[1]}, 32'd0);
        end
        chk("t3_i_rdata", bus.i_rdata, 32'h1234_5678);

        // 4: continuous data requests starve fetch until the limit
        grants.delete();
        exp_seq = "DDDDIDDDDI";
        resp_lat = 1; resp_data = 32'h0BAD_F00D;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_4000;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0200;
        for (int k = 0; k < 400 && grants.size() < exp_seq.len(); k++) begin
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_grant_count_min", {31'h0, grants.size() >= exp_seq.len()}, 32'd1);
        for (int k = 0; k < exp_seq.len() && k < grants.size(); k++)
            chk($sformatf("t4_grant%0d", k), {31'h0, grants[k]}, {31'h0, exp_seq[k] == "D"});

        // 5: reset in WAIT, then a late dn_ready
        resp_en = 1'b0;
        dr0 = dr_cnt; ir0 = ir_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_5000;
        wait_for(2, 10, "t5_strobe");
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy_before_reset", {31'h0, bus.busy}, 32'd1);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        spur_data = 32'hCAFE_0001; spur_cnt++;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_d_ready_pulses", dr_cnt - dr0, 32'd0);
        chk("t5_i_ready_pulses", ir_cnt - ir0, 32'd0);
        chk("t5_busy", {31'h0, bus.busy}, 32'd0);
        chk("t5_dn_addr", bus.dn_addr, 32'h0);
        chk("t5_d_rdata", bus.d_rdata, 32'h0);

        // 6: stray dn_ready in IDLE with no request
        re0 = re_cnt; we0 = we_cnt; dr0 = dr_cnt; ir0 = ir_cnt;
        spur_data = 32'h0BAD_0BAD; spur_cnt++;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_strobes", (re_cnt - re0) + (we_cnt - we0), 32'd0);
        chk("t6_readies", (ir_cnt - ir0) + (dr_cnt - dr0), 32'd0);
        chk("t6_i_rdata", bus.i_rdata, 32'h0);
        chk("t6_d_rdata", bus.d_rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
